// File: rtl/mode_sequencer.sv
// mode_sequencer: command-driven driver for the mode counter's mode/en inputs.
// Latency: a command accepted into an idle, empty sequencer raises en_o one edge later.
// Backpressure: cmd_ready_o drops when the command FIFO is full or abort_i is high.
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   cmd_valid_i/_o    valid/ready command handshake (cmd_ready_o is combinational)
//   cmd_mode_i        00 UP, 01 DOWN, 10 ROTL, 11 ROTR
//   cmd_cycles_i      number of enabled counter cycles; 0 is accepted and dropped
//   abort_i           synchronous flush of the FIFO and the running command
//   mode_o, en_o      registered drive to the counter
//   busy_o            command running or FIFO non-empty
//   done_o            one-cycle pulse after the last enabled edge of a command
//   level_o           FIFO occupancy

module mode_sequencer #(
    parameter int DEPTH = 4,   // power of two, >= 2
    parameter int CW    = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [1:0]               cmd_mode_i,
    input  logic [CW-1:0]            cmd_cycles_i,
    input  logic                     abort_i,
    output logic [1:0]               mode_o,
    output logic                     en_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [1:0]    fifo_mode_q [DEPTH];
    logic [CW-1:0] fifo_cyc_q  [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q,  level_d;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [1:0]    head_mode;
    logic [CW-1:0] head_cyc;

    assign full      = (level_q == LW'(DEPTH));
    assign empty     = (level_q == '0);
    assign head_mode = fifo_mode_q[rd_ptr_q];
    assign head_cyc  = fifo_cyc_q[rd_ptr_q];

    // Readiness looks only at registered occupancy: a pop in the same cycle
    // does not open a slot, which keeps this path short.
    assign cmd_ready_o = !full && !abort_i;

    // Zero-length commands complete the handshake but never reach storage,
    // so the run logic can rely on every stored count being non-zero.
    assign push = cmd_valid_i && cmd_ready_o && (cmd_cycles_i != '0);

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mode_q[wr_ptr_q] <= cmd_mode_i;
            fifo_cyc_q[wr_ptr_q]  <= cmd_cycles_i;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (abort_i) begin
            // Flush: storage contents are left as-is, the pointers define validity.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // ------------------------------------------------------------------
    // Run FSM
    // ------------------------------------------------------------------
    state_t        state_q,     state_d;
    logic [CW-1:0] remaining_q, remaining_d;
    logic [1:0]    mode_q,      mode_d;
    logic          en_q,        en_d;
    logic          done_q,      done_d;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        mode_d      = mode_q;
        en_d        = en_q;
        done_d      = 1'b0;
        pop         = 1'b0;

        if (abort_i) begin
            // Abort wins over everything; mode is deliberately left unchanged.
            state_d     = S_IDLE;
            remaining_d = '0;
            en_d        = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!empty) begin
                        pop         = 1'b1;
                        mode_d      = head_mode;
                        remaining_d = head_cyc;
                        en_d        = 1'b1;
                        state_d     = S_RUN;
                    end
                end
                S_RUN: begin
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == CW'(1)) begin
                        done_d = 1'b1;
                        if (!empty) begin
                            // Chain straight into the next command so en stays
                            // high across the boundary.
                            pop         = 1'b1;
                            mode_d      = head_mode;
                            remaining_d = head_cyc;
                        end else begin
                            en_d    = 1'b0;
                            state_d = S_IDLE;
                        end
                    end
                end
                default: begin
                    state_d     = S_IDLE;
                    remaining_d = '0;
                    en_d        = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            mode_q      <= 2'b00;
            en_q        <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            mode_q      <= mode_d;
            en_q        <= en_d;
            done_q      <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mode_o  = mode_q;
    assign en_o    = en_q;
    assign done_o  = done_q;
    assign level_o = level_q;
    assign busy_o  = (state_q == S_RUN) || (level_q != '0);

endmodule

// File: tb/tb_mode_sequencer.sv
// tb_mode_sequencer: directed scenarios plus random traffic for mode_sequencer,
// checked every cycle against a queue-based model of pending commands and
// remaining enabled cycles.

module tb_mode_sequencer;

    localparam int DEPTH = 4;
    localparam int CW    = 8;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready_o;
    logic [1:0]  cmd_mode;
    logic [7:0]  cmd_cycles;
    logic        abort;
    logic [1:0]  mode_o;
    logic        en_o;
    logic        busy_o;
    logic        done_o;
    logic [2:0]  level_o;

    mode_sequencer #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_mode_i   (cmd_mode),
        .cmd_cycles_i (cmd_cycles),
        .abort_i      (abort),
        .mode_o       (mode_o),
        .en_o         (en_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .level_o      (level_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [1:0] m;
        int         c;
    } cmd_t;

    cmd_t       q[$];      // stored, not yet started commands
    int         left;      // enabled cycles still owed to the running command
    logic [1:0] m_mode;
    bit         m_en;
    bit         m_done;

    task automatic model_reset();
        q.delete();
        left   = 0;
        m_mode = 2'b00;
        m_en   = 1'b0;
        m_done = 1'b0;
    endtask

    task automatic model_edge(input bit v, input logic [1:0] md, input int cy, input bit ab);
        bit   acc;
        cmd_t h;
        acc    = v && !ab && (q.size() < DEPTH);
        m_done = 1'b0;
        if (ab) begin
            q.delete();
            left = 0;
        end else begin
            if (left > 0) begin
                left--;
                m_done = (left == 0);
            end
            if (left == 0 && q.size() > 0) begin
                h      = q.pop_front();
                left   = h.c;
                m_mode = h.m;
            end
            if (acc && cy != 0) begin
                h.m = md;
                h.c = cy;
                q.push_back(h);
            end
        end
        m_en = (left > 0);
    endtask

    // ---------------- observation window ----------------
    int         en_cnt;
    int         done_cnt;
    int         rise_cnt;
    bit         prev_en;
    logic [1:0] mode_log[$];

    task automatic clear_win();
        en_cnt   = 0;
        done_cnt = 0;
        rise_cnt = 0;
        prev_en  = en_o;
        mode_log.delete();
    endtask

    // One clock cycle: drive at negedge, check ready, advance model at posedge,
    // check registered outputs 1 ns later.
    task automatic step(input bit v, input logic [1:0] md, input int cy, input bit ab);
        @(negedge clk);
        cmd_valid  = v;
        cmd_mode   = md;
        cmd_cycles = cy[7:0];
        abort      = ab;
        #1;
        chk("ready", cmd_ready_o, int'(!ab && (q.size() < DEPTH)));
        @(posedge clk);
        model_edge(v, md, cy, ab);
        #1;
        chk("en",    en_o,    m_en);
        chk("mode",  mode_o,  m_mode);
        chk("done",  done_o,  m_done);
        chk("busy",  busy_o,  int'((left > 0) || (q.size() > 0)));
        chk("level", level_o, q.size());
        if (en_o) begin
            en_cnt++;
            mode_log.push_back(mode_o);
        end
        if (done_o) done_cnt++;
        if (en_o && !prev_en) rise_cnt++;
        prev_en   = en_o;
        cmd_valid = 1'b0;
        abort     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 2'b00, 0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_mode[$];
        bool_dummy_init();
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_mode   = 2'b00;
        cmd_cycles = 8'd0;
        abort      = 1'b0;
        model_reset();

        // Test 1a: reset values before any clock edge
        #1;
        chk("rst0_en",    en_o,        0);
        chk("rst0_mode",  mode_o,      0);
        chk("rst0_busy",  busy_o,      0);
        chk("rst0_done",  done_o,      0);
        chk("rst0_level", level_o,     0);
        chk("rst0_ready", cmd_ready_o, 1);
        @(negedge clk);
        rst = 1'b0;

        // Test 2: single UP/5
        clear_win();
        step(1, 2'b00, 5, 0);
        idle(7);
        chk("t2_en_cycles", en_cnt,   5);
        chk("t2_done",      done_cnt, 1);
        chk("t2_rises",     rise_cnt, 1);
        chk("t2_busy_end",  busy_o,   0);
        foreach (mode_log[i]) chk("t2_mode", mode_log[i], 0);

        // Test 3: queued UP/5, DOWN/4, ROTL/3, ROTR/6
        clear_win();
        step(1, 2'b00, 5, 0);
        step(1, 2'b01, 4, 0);
        step(1, 2'b10, 3, 0);
        step(1, 2'b11, 6, 0);
        idle(20);
        chk("t3_en_cycles", en_cnt,   18);
        chk("t3_rises",     rise_cnt, 1);
        chk("t3_done",      done_cnt, 4);
        exp_mode.delete();
        for (int i = 0; i < 5; i++) exp_mode.push_back(2'b00);
        for (int i = 0; i < 4; i++) exp_mode.push_back(2'b01);
        for (int i = 0; i < 3; i++) exp_mode.push_back(2'b10);
        for (int i = 0; i < 6; i++) exp_mode.push_back(2'b11);
        chk("t3_log_len", mode_log.size(), 18);
        for (int i = 0; i < 18 && i < mode_log.size(); i++)
            chk($sformatf("t3_mode%0d", i), mode_log[i], exp_mode[i]);

        // Test 4: FIFO full behind a long command
        step(1, 2'b00, 40, 0);
        idle(1);
        step(1, 2'b01, 2, 0);
        step(1, 2'b10, 2, 0);
        step(1, 2'b11, 2, 0);
        step(1, 2'b01, 2, 0);
        chk("t4_level_full", level_o,     DEPTH);
        chk("t4_ready_full", cmd_ready_o, 0);
        step(1, 2'b10, 3, 0);   // offered while full, must be ignored
        chk("t4_level_hold", level_o, DEPTH);
        for (int i = 0; i < 60 && level_o == 3'(DEPTH); i++) idle(1);
        chk("t4_level_pop", level_o,     DEPTH - 1);
        chk("t4_ready_pop", cmd_ready_o, 1);
        idle(20);

        // Test 5: ROTR/0 then UP/2
        clear_win();
        step(1, 2'b11, 0, 0);
        chk("t5_zero_level", level_o, 0);
        step(1, 2'b00, 2, 0);
        idle(6);
        chk("t5_en_cycles", en_cnt,   2);
        chk("t5_done",      done_cnt, 1);
        foreach (mode_log[i]) chk("t5_mode", mode_log[i], 0);

        // Maximum run length
        clear_win();
        step(1, 2'b10, 255, 0);
        idle(258);
        chk("max_en_cycles", en_cnt,   255);
        chk("max_done",      done_cnt, 1);

        // Test 6: abort in the 3rd cycle of DOWN/8 with two queued
        step(1, 2'b01, 8, 0);
        step(1, 2'b00, 3, 0);
        step(1, 2'b10, 3, 0);
        idle(1);
        chk("t6_level_pre", level_o, 2);
        chk("t6_en_pre",    en_o,    1);
        step(1, 2'b11, 5, 1);
        chk("t6_en",    en_o,    0);
        chk("t6_level", level_o, 0);
        chk("t6_done",  done_o,  0);
        chk("t6_mode",  mode_o,  1);
        clear_win();
        idle(10);
        chk("t6_en_after",   en_cnt,   0);
        chk("t6_done_after", done_cnt, 0);

        // Test 1b: asynchronous reset mid-run with a command queued
        step(1, 2'b11, 20, 0);
        step(1, 2'b01, 5, 0);
        idle(2);
        chk("t1_en_pre",   en_o,   1);
        chk("t1_mode_pre", mode_o, 3);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t1_en",    en_o,        0);
        chk("t1_mode",  mode_o,      0);
        chk("t1_busy",  busy_o,      0);
        chk("t1_done",  done_o,      0);
        chk("t1_level", level_o,     0);
        chk("t1_ready", cmd_ready_o, 1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle(3);

        // Random traffic
        for (int i = 0; i < 700; i++) begin
            bit         v;
            bit         ab;
            logic [1:0] md;
            int         cy;
            v  = ($urandom_range(0, 1) == 1);
            md = 2'($urandom_range(0, 3));
            cy = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 40))
                                              : int'($urandom_range(0, 6));
            ab = ($urandom_range(0, 29) == 0);
            step(v, md, cy, ab);
        end
        idle(60);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    function automatic void bool_dummy_init();
        prev_en = 1'b0;
    endfunction

endmodule

// File: doc/mode_sequencer.md
# mode_sequencer

Command-driven sequencer that sits directly upstream of the N-bit mode counter and generates its `mode` and `en` inputs. It accepts (mode, cycle-count) commands over a valid/ready interface and buffers them in a small FIFO. It replays them back-to-back, asserting `en` for exactly the requested number of clock cycles per command with `mode` held stable. Status outputs report progress to the system controller.

## Interface
- `DEPTH`, 4, command FIFO entries; power of two, ≥ 2
- `CW`, 8, width of the cycle-count field

- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `cmd_valid`  in  1  command present on `cmd_mode`/`cmd_cycles`
- `cmd_ready`  out  1  sequencer can take a command this cycle
- `cmd_mode`  in  2  00 UP, 01 DOWN, 10 ROTL, 11 ROTR
- `cmd_cycles`  in  CW  number of enabled counter cycles
- `abort`  in  1  synchronous flush of FIFO and current command
- `mode`  out  2  to counter `mode`, registered
- `en`  out  1  to counter `en`, registered
- `busy`  out  1  command executing or FIFO non-empty
- `done`  out  1  one-cycle pulse when a command completes normally
- `level`  out  clog2(DEPTH)+1  FIFO occupancy

## Operation
- **Reset values** (`rst` high, asynchronous):
  - Outputs: `mode`=00, `en`=0, `busy`=0, `done`=0, `level`=0, `cmd_ready`=1.
  - Internal: FIFO empty, FSM in IDLE, remaining counter cleared.
- **Accept:** a command is accepted on a rising edge with `cmd_valid && cmd_ready`.
  - `cmd_ready` = !full && !abort. It is combinational, and a same-cycle pop does not free a slot.
  - `cmd_cycles`=0: the command is accepted, then discarded. It is not stored, and produces no `en` and no `done`.
- **FSM states:**
  - IDLE: `en`=0. On an edge with FIFO non-empty:
    - pop the head;
    - `mode`←head.mode, `remaining`←head.cycles, `en`←1;
    - go to RUN.
  - RUN: `en`=1. Each edge decrements `remaining`. On the edge where `remaining`==1:
    - `done`←1 for the next cycle.
    - If the FIFO is non-empty: pop, load the new mode/count, keep `en`=1 (no gap) and stay in RUN.
    - Otherwise: `en`←0, go to IDLE, and keep `mode` at its last value.
- **Mode hold:** `mode` changes only on a pop edge and never while a command is mid-run.
- **Abort:** on an edge with `abort`=1:
  - flush the FIFO (`level`←0), `en`←0, go to IDLE;
  - `remaining` cleared, no `done` pulse, `mode` keeps its last value.
  - Abort takes priority over pop and over push.
- **`busy`** = (state==RUN) || (`level`≠0), registered-state derived.
- **Width rules:**
  - `remaining` is CW bits wide and never wraps: it is only decremented in RUN, and a zero count is never loaded.
  - Maximum run length is 2^CW−1 cycles.
- **Counters:** FIFO pointers are clog2(DEPTH) bits and wrap modulo DEPTH. `level` saturates at DEPTH by construction (push is blocked when full).

## Timing
- **Latency:** a command accepted at edge k with the sequencer IDLE and the FIFO empty gives `en`=1 from edge k+1. The command is visible in the FIFO after edge k and popped at edge k+1.
- **Duration:** `en` stays high for exactly `cmd_cycles` consecutive rising edges per command. That is exactly the number of counter updates.
- **Back-to-back:** consecutive queued commands produce a contiguous `en` with `mode` switching on the boundary edge.
- **`done`:** asserted for the single cycle following the final enabled edge of each completed command. Back-to-back commands produce separate one-cycle pulses.
- **Simultaneous push and pop:** `level` is unchanged, and both operations complete.
- **Reset mid-run:** all outputs return to reset values immediately, without waiting for a clock edge. Queued commands are lost.

## Test plan
1. **Reset:** assert `rst` mid-cycle with no clock. Require `en`=0, `mode`=00, `busy`=0, `level`=0, `cmd_ready`=1 immediately.
2. **Single command:** send UP/5 with the sequencer idle. Require:
   - `en` high for exactly 5 edges starting one edge after acceptance, with `mode`=00 throughout;
   - one `done` pulse;
   - `busy` low after completion.
3. **Queued sequence:** queue UP/5, DOWN/4, ROTL/3, ROTR/6. Require:
   - 18 contiguous `en` cycles;
   - `mode` steps 00→01→10→11 at edges 5, 9 and 12 after the first;
   - four `done` pulses.
4. **FIFO full:** with a long command running, push DEPTH more commands. Require `cmd_ready`=0 and `level`=DEPTH. On the next pop, require `cmd_ready` back to 1 and `level`=DEPTH−1.
5. **Zero count:** send ROTR/0 then UP/2. Require no `en` for ROTR, then `en` high for 2 cycles with `mode`=00, and exactly one `done`.
6. **Abort:** pulse `abort` during the 3rd cycle of DOWN/8 with 2 commands queued. Require:
   - `en`=0 next cycle, `level`=0, no `done`;
   - `mode` stays 01;
   - a `cmd_valid` held during the abort cycle is not accepted.
